mem_access_ctrl: RTL and testbench

MEM-stage sequencer between the pipeline and a word-wide data memory with variable latency and a ready handshake. Issues reads and writes, and performs read-modify-write for SB/SH. Sign- or zero-extends load results and stalls the pipeline until each access completes. A watchdog flags a memory that never answers.

---
 rtl/mem_pkg.sv | 58 +++++
 rtl/load_extend.sv | 31 +++
 rtl/mem_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage memory access controller.
//   - MIPS load/store primary opcodes
//   - sequencer state encoding
//   - watchdog counter width
//   - byte/halfword lane selection and store-merge helpers
package mem_pkg;

    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpSb  = 6'b101000;
    localparam logic [5:0] OpSh  = 6'b101001;
    localparam logic [5:0] OpSw  = 6'b101011;

    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw};
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
    endfunction

    // Little-endian: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] lane_half(input logic [31:0] w, input logic hi);
        return w[{hi, 4'b0000} +: 16];
    endfunction

    // Read-modify-write merge for SB/SH; other opcodes return the old word untouched.
    function automatic logic [31:0] merge_store(input logic [5:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] data);
        logic [31:0] w;
        w = old_word;
        if (op == OpSb) begin
            w[{lane, 3'b000} +: 8] = data[7:0];
        end else if (op == OpSh) begin
            w[{lane[1], 4'b0000} +: 16] = data[15:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extension (combinational).
//   opcode  : load opcode (LB/LH/LW/LBU/LHU); anything else passes the word
//   addr_lo : byte address bits [1:0], selects the lane
//   word    : raw 32-bit memory word
//   result  : sign- or zero-extended load value
module load_extend
    import mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = lane_byte(word, addr_lo);
        h      = lane_half(word, addr_lo[1]);
        result = word;
        case (opcode)
            OpLb:    result = {{24{b[7]}}, b};
            OpLbu:   result = {24'b0, b};
            OpLh:    result = {{16{h[15]}}, h};
            OpLhu:   result = {16'b0, h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer between the pipeline and a variable-latency word memory.
// Performs loads, word stores and read-modify-write for SB/SH, extends load
// results, stalls the pipeline until each access completes and raises a bus
// error when the memory fails to answer within TIMEOUT_CYC cycles.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req_valid, opcode    : memory instruction present in MEM, MIPS primary opcode
//   addr, wdata          : byte address and store data
//   stall                : freeze upstream stages
//   rdata, rdata_valid   : extended load result and its valid strobe
//   exc_align, exc_bus   : one-cycle misalignment / timeout pulses
//   mem_addr             : word address to memory
//   mem_re, mem_we       : registered read / write requests, held until mem_ready
//   mem_wdata            : write word
//   mem_rdata, mem_ready : read word and request completion from memory
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses
// instead of silently ignoring the low address bits.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              exc_align,
    output logic              exc_bus,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);

    state_t          state_q;
    logic [5:0]      op_q;
    logic [1:0]      lane_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     ext_word;
    logic            new_req;
    logic            misalign;

    assign new_req = req_valid && is_mem_op(opcode);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (opcode)
            OpLh, OpLhu, OpSh: misalign = addr[0];
            OpLw, OpSw:        misalign = (addr[1:0] != 2'b00);
            default:           misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Extension runs on the incoming word so the result can be registered into RESP.
    load_extend u_load_extend (
        .opcode  (op_q),
        .addr_lo (lane_q),
        .word    (mem_rdata),
        .result  (ext_word)
    );

    // The request cycle itself must already stall, hence the IDLE term.
    assign stall = (state_q == StIdle && new_req) || state_q == StRd || state_q == StWr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            exc_align   <= 1'b0;
            exc_bus     <= 1'b0;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            rdata_valid <= 1'b0;
            exc_align   <= 1'b0;
            exc_bus     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (new_req) begin
                        op_q     <= opcode;
                        lane_q   <= addr[1:0];
                        mem_addr <= addr[ADDR_W-1:2];
                        cnt_q    <= '0;
                        if (misalign) begin
                            exc_align <= 1'b1;
                            state_q   <= StResp;
                        end else if (opcode == OpSw) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                            state_q   <= StWr;
                        end else begin
                            mem_re  <= 1'b1;
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (mem_ready) begin
                        mem_re <= 1'b0;
                        if (is_load(op_q)) begin
                            rdata       <= ext_word;
                            rdata_valid <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            // wdata is still valid: the pipeline is frozen while stalled.
                            mem_wdata <= merge_store(op_q, lane_q, mem_rdata, wdata);
                            mem_we    <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StWr;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q + CntW'(1) == TimeoutVal) begin
                            mem_re  <= 1'b0;
                            exc_bus <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StWr: begin
                    if (mem_ready) begin
                        mem_we  <= 1'b0;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q + CntW'(1) == TimeoutVal) begin
                            mem_we  <= 1'b0;
                            exc_bus <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a transaction-level model predicts the
// per-cycle outputs of every access, a memory responder answers with planned
// latencies, and one compare process checks the DUT each cycle.
module tb_mem_access_ctrl;

    localparam int T = 4;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_align;
    logic        exc_bus;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [31:0] dut_mem [64];
    logic [31:0] ref_mem [64];
    int          d_rd;
    int          d_wr;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        stall, re, we, rv, eb, ea;
        logic [31:0] rd, wd;
        logic [29:0] ma;
    } exp_t;

    exp_t expq[$];

    always #5 clk = ~clk;

    assign mem_rdata = dut_mem[mem_addr[5:0]];

    mem_access_ctrl #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .opcode      (opcode),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .exc_align   (exc_align),
        .exc_bus     (exc_bus),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic re, input logic we, input logic rv,
                                input logic eb, input logic ea, input logic [31:0] rd,
                                input logic [31:0] wd, input logic [29:0] ma);
        exp_t e;
        e.stall = s; e.re = re; e.we = we; e.rv = rv; e.eb = eb; e.ea = ea;
        e.rd = rd; e.wd = wd; e.ma = ma;
        return e;
    endfunction

    function automatic logic [31:0] ext(input logic [5:0] op, input logic [1:0] lo,
                                        input logic [31:0] w);
        logic [31:0] v;
        if (op == LW) return w;
        if (op == LB || op == LBU) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (op == LB && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * lo[1])) & 32'hFFFF;
            if (op == LH && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [5:0] op, input logic [1:0] lo,
                                          input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        mask = (op == SB) ? 32'hFF : 32'hFFFF;
        sh   = (op == SB) ? 8 * lo : 16 * lo[1];
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        dut_mem[a[7:2]] = w;
        ref_mem[a[7:2]] = w;
    endtask

    // Predict the full cycle trace of one access, then present it for that many cycles.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input int drd, input int dwr, output int n, output logic [31:0] res);
        logic [31:0] old, nw;
        logic [29:0] ma;
        logic        ld, to, mis;
        int          k;
        old = ref_mem[a[7:2]];
        ma  = a[31:2];
        n   = 0;
        res = 0;
        to  = 1'b0;
        nw  = wd;
        ld  = (op == LB || op == LH || op == LW || op == LBU || op == LHU);
        if (!(ld || op == SB || op == SH || op == SW)) begin
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            n = 1;
        end else begin
            mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis = ((op == LH || op == LHU || op == SH) && a[0]) ||
                  ((op == LW || op == SW) && a[1:0] != 2'b00);
`endif
            expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
            n = 1;
            if (mis) begin
                expq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
                n++;
            end else begin
                if (op != SW) begin
                    k = (drd < T) ? drd + 1 : T;
                    repeat (k) expq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, ma));
                    n += k;
                    to = (drd >= T);
                    if (!to && ld) res = ext(op, a[1:0], old);
                    if (!ld) nw = merge(op, a[1:0], old, wd);
                end
                if (!to && !ld) begin
                    k = (dwr < T) ? dwr + 1 : T;
                    repeat (k) expq.push_back(mk(1, 0, 1, 0, 0, 0, 0, nw, ma));
                    n += k;
                    to = (dwr >= T);
                    if (!to) ref_mem[a[7:2]] = nw;
                end
                expq.push_back(mk(0, 0, 0, ld && !to, to, 0, res, 0, 0));
                n++;
            end
        end
        d_rd      = drd;
        d_wr      = dwr;
        opcode    = op;
        addr      = a;
        wdata     = wd;
        req_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
    endtask

    // Compare process: one expected entry per cycle while a transaction is in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                check("stall", stall, e.stall);
                check("mem_re", mem_re, e.re);
                check("mem_we", mem_we, e.we);
                check("rdata_valid", rdata_valid, e.rv);
                check("exc_bus", exc_bus, e.eb);
                check("exc_align", exc_align, e.ea);
                if (e.rv) check("rdata", rdata, e.rd);
                if (e.re || e.we) check("mem_addr", mem_addr, e.ma);
                if (e.we) check("mem_wdata", mem_wdata, e.wd);
            end
        end
    end

    // Memory responder: ready after the planned number of wait cycles; random noise when idle.
    initial begin
        logic [1:0] last = 2'b00;
        logic [1:0] key;
        int         cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            key = {mem_re, mem_we};
            if (key == 2'b00) begin
                cnt       = 0;
                mem_ready = 1'($urandom_range(0, 1));
            end else begin
                if (key != last) cnt = 0;
                else cnt++;
                mem_ready = (cnt == (mem_re ? d_rd : d_wr));
            end
            last = key;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && mem_we === 1'b1 && mem_ready === 1'b1)
                dut_mem[mem_addr[5:0]] = mem_wdata;
        end
    end

    initial begin
        int          n;
        logic [31:0] r;
        logic [5:0]  ops [12];
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, LW, SW,
                6'b100010, 6'b001000};
        reset     = 1'b1;
        req_valid = 1'b0;
        opcode    = '0;
        addr      = '0;
        wdata     = '0;
        d_rd      = 0;
        d_wr      = 0;
        for (int i = 0; i < 64; i++) begin
            dut_mem[i] = $urandom;
            ref_mem[i] = dut_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_exc", {exc_bus, exc_align}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        preload(32'h103, 32'h80AA_55CC);
        run_txn(LB, 32'h103, 0, 0, 0, n, r);
        check("lb_model_rdata", r, 32'hFFFF_FF80);
        check("lb_cycles", n, 3);

        preload(32'h102, 32'h9ABC_1234);
        run_txn(LHU, 32'h102, 0, 3, 0, n, r);
        check("lhu_model_rdata", r, 32'h0000_9ABC);
        check("lhu_cycles", n, 6);
        run_txn(LH, 32'h102, 0, 0, 0, n, r);
        check("lh_model_rdata", r, 32'hFFFF_9ABC);

        preload(32'h201, 32'h1122_3344);
        run_txn(SB, 32'h201, 32'h0000_00EE, 0, 0, n, r);
        check("sb_cycles", n, 4);
        check("sb_model_word", ref_mem[0], 32'h1122_EE44);
        check("sb_mem_word", dut_mem[0], 32'h1122_EE44);

        run_txn(SW, 32'h20, 32'hCAFE_F00D, 0, 0, n, r);
        check("sw_cycles", n, 3);

        run_txn(LW, 32'h10, 0, 99, 0, n, r);
        check("timeout_cycles", n, 6);

        // Reset while an SH sits in WR: the write must be abandoned.
        preload(32'h44, 32'h5566_7788);
        d_rd = 0; d_wr = 99;
        opcode = SH; addr = 32'h46; wdata = 32'h0000_ABCD; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rmw_in_wr_we", mem_we, 1);
        check("rmw_in_wr_wdata", mem_wdata, 32'hABCD_7788);
        reset = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_rst_we", mem_we, 0);
        check("rmw_rst_stall", stall, 0);
        check("rmw_rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        check("rmw_rst_mem", dut_mem[6'h11], 32'h5566_7788);
        run_txn(LW, 32'h44, 0, 1, 0, n, r);
        check("post_rst_lw", r, 32'h5566_7788);

        run_txn(LW, 32'h102, 0, 0, 0, n, r);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_cycles", n, 2);
`else
        check("lw_mis_cycles", n, 3);
`endif

        for (int i = 0; i < 300; i++) begin
            run_txn(ops[$urandom_range(0, 11)], 32'($urandom_range(0, 255)), $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 5), n, r);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) check("final_mem", dut_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
